// File: rtl/switch_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, counter debounce, registered
// press/release pulses and an optional auto-repeat while the button is held.
module switch_debounce_pulse #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_EN      = 1,
  parameter int HOLD_LIMIT     = 12500000,
  parameter int REPEAT_PERIOD  = 2500000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Press,
  output logic o_Release,
  output logic o_Hold
);

  localparam int DW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int HW = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT) : 1;
  localparam int RW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_LIMIT - 1);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          hold_q, hold_d;
  logic          rise, fall;

  // The level only follows the synchronised input after DEBOUNCE_LIMIT
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    if (sync2_q != level_q) begin
      if (dcnt_q == DLAST) begin
        level_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  // Edge pulses are computed from level_d so they line up with the first
  // cycle the new level is visible; a fall overrides any repeat due that cycle.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    rcnt_d    = rcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (fall) begin
      state_d   = IDLE;
      hcnt_d    = '0;
      rcnt_d    = '0;
      release_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PRESSED;
            hcnt_d  = '0;
            rcnt_d  = '0;
            press_d = 1'b1;
          end
        end
        PRESSED: begin
          if (hcnt_q == HLAST) begin
            if (REPEAT_EN != 0) begin
              state_d = REPEAT;
              rcnt_d  = '0;
              press_d = 1'b1;
            end
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (rcnt_q == RLAST) begin
            rcnt_d  = '0;
            press_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
          rcnt_d  = '0;
        end
      endcase
    end
    hold_d = (state_d == REPEAT);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      dcnt_q    <= '0;
      state_q   <= IDLE;
      hcnt_q    <= '0;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      sync1_q   <= i_Switch;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      rcnt_q    <= rcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
    end
  end

  assign o_Level   = level_q;
  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Hold    = hold_q;

endmodule

// File: tb/tb_switch_debounce_pulse.sv
// Bench for switch_debounce_pulse: two instances (repeat on/off) compared every
// cycle against a sample-history reference model, plus directed timing checks.
module tb_switch_debounce_pulse;

  localparam int L = 4;
  localparam int H = 20;
  localparam int P = 8;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  logic i_switch = 1'b0;
  logic o_level_r, o_press_r, o_release_r, o_hold_r;
  logic o_level_nr, o_press_nr, o_release_nr, o_hold_nr;

  int n_compared = 0;
  int n_mismatched = 0;
  bit started = 1'b0;

  always #5 i_clk = ~i_clk;

  switch_debounce_pulse #(
    .DEBOUNCE_LIMIT(L), .REPEAT_EN(1), .HOLD_LIMIT(H), .REPEAT_PERIOD(P)
  ) dut_r (
    .i_Clk(i_clk), .i_Reset(i_reset), .i_Switch(i_switch),
    .o_Level(o_level_r), .o_Press(o_press_r), .o_Release(o_release_r), .o_Hold(o_hold_r)
  );

  switch_debounce_pulse #(
    .DEBOUNCE_LIMIT(L), .REPEAT_EN(0), .HOLD_LIMIT(H), .REPEAT_PERIOD(P)
  ) dut_nr (
    .i_Clk(i_clk), .i_Reset(i_reset), .i_Switch(i_switch),
    .o_Level(o_level_nr), .o_Press(o_press_nr), .o_Release(o_release_nr), .o_Hold(o_hold_nr)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference model: hist[k] is i_switch as sampled k edges ago. The level
  // flips once the L samples seen by the debouncer all disagree with it.
  bit hist[$];
  int n_edge, t0;
  bit m_level, m_press_r, m_press_nr, m_release, m_hold_r;

  function automatic void model_clear();
    hist.delete();
    for (int k = 0; k < L + 2; k++) hist.push_back(1'b0);
    n_edge = 0;
    t0 = 0;
    m_level = 1'b0;
    m_press_r = 1'b0;
    m_press_nr = 1'b0;
    m_release = 1'b0;
    m_hold_r = 1'b0;
  endfunction

  function automatic void model_step(input bit sw);
    bit all_differ;
    int dt;
    n_edge++;
    hist.push_front(sw);
    void'(hist.pop_back());
    all_differ = 1'b1;
    for (int k = 2; k < L + 2; k++) if (hist[k] == m_level) all_differ = 1'b0;
    m_press_r = 1'b0;
    m_press_nr = 1'b0;
    m_release = 1'b0;
    if (all_differ) begin
      m_level = ~m_level;
      if (m_level) begin
        t0 = n_edge;
        m_press_r = 1'b1;
        m_press_nr = 1'b1;
      end else begin
        m_release = 1'b1;
      end
    end else if (m_level) begin
      dt = n_edge - t0;
      if (dt >= H && ((dt - H) % P) == 0) m_press_r = 1'b1;
    end
    m_hold_r = m_level && ((n_edge - t0) >= H);
  endfunction

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) model_clear();
    else model_step(i_switch);
  end

  always @(negedge i_clk) begin
    if (started) begin
      checkOutput("level_r", o_level_r, m_level);
      checkOutput("press_r", o_press_r, m_press_r);
      checkOutput("release_r", o_release_r, m_release);
      checkOutput("hold_r", o_hold_r, m_hold_r);
      checkOutput("level_nr", o_level_nr, m_level);
      checkOutput("press_nr", o_press_nr, m_press_nr);
      checkOutput("release_nr", o_release_nr, m_release);
      checkOutput("hold_nr", o_hold_nr, 0);
    end
  end

  task automatic applyStimulus(input bit value, input int cycles);
    i_switch = value;
    repeat (cycles) @(negedge i_clk);
  endtask

  // Counts rising edges until o_Press on the repeat instance, bounded.
  task automatic wait_press(output int lat);
    bit got;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge i_clk);
      #1;
      lat++;
      if (o_press_r) got = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_level"}, o_level_r, 0);
    checkOutput({tag, "_press"}, o_press_r, 0);
    checkOutput({tag, "_release"}, o_release_r, 0);
    checkOutput({tag, "_hold"}, o_hold_r, 0);
    checkOutput({tag, "_level_nr"}, o_level_nr, 0);
    checkOutput({tag, "_press_nr"}, o_press_nr, 0);
  endtask

  initial begin
    int lat, act, pr, pnr, rel, rel_off, hold_first, hold_at_rel;
    model_clear();
    i_switch = 1'b1;
    i_reset = 1'b1;
    started = 1'b1;
    #2;
    check_all_zero("t1_reset");
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    wait_press(lat);
    checkOutput("t1_latency", lat, L + 2);
    checkOutput("t1_level", o_level_r, 1);
    @(posedge i_clk);
    #1;
    checkOutput("t1_single", o_press_r, 0);
    @(negedge i_clk);
    applyStimulus(1'b0, 30);

    for (int i = 0; i < 10; i++) applyStimulus((i % 2) == 0, 2);
    i_switch = 1'b1;
    wait_press(lat);
    checkOutput("t2_latency", lat, L + 2);
    @(negedge i_clk);
    applyStimulus(1'b0, 30);

    act = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge i_clk);
      i_switch = (c < 3);
      @(posedge i_clk);
      #1;
      act += o_level_r + o_press_r + o_release_r;
    end
    checkOutput("t3_glitch_activity", act, 0);

    @(negedge i_clk);
    i_switch = 1'b1;
    wait_press(lat);
    checkOutput("t4_latency", lat, L + 2);
    pr = 1;
    pnr = o_press_nr;
    hold_first = -1;
    for (int off = 1; off < 60; off++) begin
      @(posedge i_clk);
      #1;
      pr += o_press_r;
      pnr += o_press_nr;
      if (o_hold_r && hold_first < 0) hold_first = off;
      if (off == 59) i_switch = 1'b0;
    end
    checkOutput("t4_presses", pr, 6);
    checkOutput("t4_presses_norepeat", pnr, 1);
    checkOutput("t4_hold_start", hold_first, H);
    rel = 0;
    rel_off = -1;
    hold_at_rel = 1;
    for (int off = 60; off < 86; off++) begin
      @(posedge i_clk);
      #1;
      if (o_release_r) begin
        rel++;
        rel_off = off;
        hold_at_rel = o_hold_r;
      end
    end
    checkOutput("t5_releases", rel, 1);
    checkOutput("t5_release_offset", rel_off, 65);
    checkOutput("t5_hold_at_release", hold_at_rel, 0);
    applyStimulus(1'b0, 10);

    i_switch = 1'b1;
    wait_press(lat);
    pr = 1;
    rel = 0;
    rel_off = -1;
    for (int off = 1; off < 46; off++) begin
      @(posedge i_clk);
      #1;
      pr += o_press_r;
      if (o_release_r) begin
        rel++;
        rel_off = off;
      end
      if (off == 30) i_switch = 1'b0;
    end
    checkOutput("t5b_presses", pr, 3);
    checkOutput("t5b_releases", rel, 1);
    checkOutput("t5b_release_offset", rel_off, 36);
    applyStimulus(1'b0, 10);

    i_switch = 1'b1;
    wait_press(lat);
    repeat (25) @(posedge i_clk);
    #1;
    checkOutput("t6_hold_before_reset", o_hold_r, 1);
    @(negedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    check_all_zero("t6_reset");
    i_switch = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    act = 0;
    repeat (20) begin
      @(posedge i_clk);
      #1;
      act += o_release_r + o_release_nr;
    end
    checkOutput("t6_no_release", act, 0);

    @(negedge i_clk);
    for (int seg = 0; seg < 40; seg++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
    end
    applyStimulus(1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
